vram_arbiter: RTL and testbench

Shares the single-port 16-bit VRAM between the VGA scan-out fetcher and the CPU memory-mapped screen port. Display reads get a fixed one-cycle latency and are never stalled. CPU writes are posted into a small write buffer, and CPU reads are serviced in the remaining slots with read-after-write ordering preserved. The block sits between the VGA/CPU requesters and the VRAM storage array, whose read data is registered.

---
 rtl/vram_arb_pkg.sv | 19 +
 rtl/vram_wbuf.sv | 53 +++++
 rtl/vram_arbiter.sv | 123 ++++++++++++
 tb/tb_vram_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and default widths for the VRAM arbiter.
package vram_arb_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_DISP,
        SLOT_WRITE,
        SLOT_READ
    } slot_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/vram_wbuf.sv
// Posted-write FIFO holding {addr, data} entries for the VRAM arbiter.
// Latency: pushed entry visible at head the cycle after the push.
// Backpressure: full flag; pushes while full and pops while empty are ignored.
module vram_wbuf #(
    parameter int W     = 30,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == LW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_dat = store[rd_ptr];
    assign level    = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads > posted CPU writes > CPU reads.
// Latency: display data 1 cycle after request; CPU read data >= 2 cycles after acceptance.
// Backpressure: cpu_ready low while the write buffer is full or a read is pending; display never stalls.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         disp_req,
    input  logic [ADDR_W-1:0]            disp_addr,
    output logic                         disp_valid,
    output logic [DATA_W-1:0]            disp_data,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    output logic                         cpu_ready,
    output logic                         cpu_rvalid,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_we,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic [$clog2(WBUF_DEPTH):0]  wbuf_level
);

    localparam int EW = ADDR_W + DATA_W;

    slot_t              slot;
    slot_t              slot_q;
    logic               wbuf_full;
    logic               wbuf_empty;
    logic [EW-1:0]      head_dat;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;
    logic               rd_pending;
    logic [ADDR_W-1:0]  rd_addr;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               wr_accept;
    logic               rd_accept;

    assign cpu_ready = ~reset & ~wbuf_full & ~rd_pending;
    assign wr_accept = cpu_req & cpu_ready & cpu_we;
    assign rd_accept = cpu_req & cpu_ready & ~cpu_we;

    assign head_addr = head_dat[EW-1:DATA_W];
    assign head_data = head_dat[DATA_W-1:0];

    vram_wbuf #(
        .W     (EW),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk      (clk),
        .reset    (reset),
        .push     (wr_accept),
        .push_dat ({cpu_addr, cpu_wdata}),
        .pop      (slot == SLOT_WRITE),
        .head_dat (head_dat),
        .full     (wbuf_full),
        .empty    (wbuf_empty),
        .level    (wbuf_level)
    );

    // Reads wait for an empty buffer so they always observe the newest write.
    always_comb begin
        slot = SLOT_IDLE;
        if (reset)             slot = SLOT_IDLE;
        else if (disp_req)     slot = SLOT_DISP;
        else if (!wbuf_empty)  slot = SLOT_WRITE;
        else if (rd_pending)   slot = SLOT_READ;
    end

    always_comb begin
        mem_addr  = addr_q;
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
        case (slot)
            SLOT_DISP:  mem_addr = disp_addr;
            SLOT_WRITE: begin
                mem_addr  = head_addr;
                mem_we    = 1'b1;
                mem_wdata = head_data;
            end
            SLOT_READ:  mem_addr = rd_addr;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q     <= SLOT_IDLE;
            rd_pending <= 1'b0;
            rd_addr    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            slot_q  <= slot;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            if (rd_accept) begin
                rd_pending <= 1'b1;
                rd_addr    <= cpu_addr;
            end else if (slot == SLOT_READ) begin
                rd_pending <= 1'b0;
            end
            if (slot_q == SLOT_READ) rdata_q <= mem_rdata;
        end
    end

    // The tag of last cycle's slot says who owns the registered RAM output now.
    assign disp_valid = (slot_q == SLOT_DISP);
    assign disp_data  = mem_rdata;
    assign cpu_rvalid = (slot_q == SLOT_READ);
    assign cpu_rdata  = (slot_q == SLOT_READ) ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed and model-checked bench for vram_arbiter with a registered-read RAM.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_req;
    logic [13:0] disp_addr;
    logic        disp_valid;
    logic [15:0] disp_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [2:0]  wbuf_level;

    int checks = 0;
    int errors = 0;

    logic [15:0] ram [0:16383];
    logic        pre_we = 1'b0;
    logic [13:0] pre_addr = '0;
    logic [15:0] pre_dat = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we)      ram[pre_addr] <= pre_dat;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    vram_arbiter #(.ADDR_W(14), .DATA_W(16), .WBUF_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .wbuf_level (wbuf_level)
    );

    task automatic preload(input logic [13:0] addr, input logic [15:0] dat);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = addr; pre_dat = dat;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        #1;
        checks += 8;
        if (disp_valid !== 1'b0) begin errors++; $display("FAIL rst_disp_valid got %b exp 0", disp_valid); end
        if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rst_cpu_rvalid got %b exp 0", cpu_rvalid); end
        if (cpu_rdata !== 16'h0) begin errors++; $display("FAIL rst_cpu_rdata got %h exp 0", cpu_rdata); end
        if (wbuf_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", wbuf_level); end
        if (mem_we !== 1'b0)     begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
        if (mem_addr !== 14'h0)  begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
        if (mem_wdata !== 16'h0) begin errors++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); end
        if (cpu_ready !== 1'b0)  begin errors++; $display("FAIL rst_cpu_ready got %b exp 0", cpu_ready); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (cpu_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b exp 1", cpu_ready); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0010; cpu_wdata = 16'hBEEF;
        #1;
        checks++;
        if (cpu_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got %b exp 1", cpu_ready); end
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0010; cpu_wdata = 16'h0;
        #1;
        checks += 4;
        if (mem_we !== 1'b1)        begin errors++; $display("FAIL wr_mem_we got %b exp 1", mem_we); end
        if (mem_addr !== 14'h0010)  begin errors++; $display("FAIL wr_mem_addr got %h exp 0010", mem_addr); end
        if (mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL wr_mem_wdata got %h exp beef", mem_wdata); end
        if (cpu_ready !== 1'b1)     begin errors++; $display("FAIL rd_ready got %b exp 1", cpu_ready); end
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        checks += 4;
        if (mem_we !== 1'b0)       begin errors++; $display("FAIL rd_slot_we got %b exp 0", mem_we); end
        if (mem_addr !== 14'h0010) begin errors++; $display("FAIL rd_slot_addr got %h exp 0010", mem_addr); end
        if (cpu_rvalid !== 1'b0)   begin errors++; $display("FAIL rd_early_rvalid got %b exp 0", cpu_rvalid); end
        if (cpu_ready !== 1'b0)    begin errors++; $display("FAIL rd_pending_ready got %b exp 0", cpu_ready); end
        @(negedge clk);
        #1;
        checks += 2;
        if (cpu_rvalid !== 1'b1)    begin errors++; $display("FAIL rd_rvalid got %b exp 1", cpu_rvalid); end
        if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_rdata got %h exp beef", cpu_rdata); end
        @(negedge clk);
        #1;
        checks += 2;
        if (cpu_rvalid !== 1'b0)    begin errors++; $display("FAIL rd_pulse got %b exp 0", cpu_rvalid); end
        if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_hold got %h exp beef", cpu_rdata); end
    endtask

    task automatic test_display();
        logic [15:0] e;
        for (int i = 0; i < 32; i++) preload(14'(i), 16'h1000 + 16'(i * 7));
        for (int i = 0; i <= 32; i++) begin
            @(negedge clk);
            disp_req  = (i < 32);
            disp_addr = 14'(i);
            #1;
            checks++;
            if (mem_we !== 1'b0) begin errors++; $display("FAIL disp_mem_we i=%0d got %b exp 0", i, mem_we); end
            if (i > 0) begin
                e = 16'h1000 + 16'((i - 1) * 7);
                checks += 2;
                if (disp_valid !== 1'b1) begin errors++; $display("FAIL disp_valid i=%0d got %b exp 1", i, disp_valid); end
                if (disp_data !== e)     begin errors++; $display("FAIL disp_data i=%0d got %h exp %h", i, disp_data, e); end
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (disp_valid !== 1'b0) begin errors++; $display("FAIL disp_idle got %b exp 0", disp_valid); end
    endtask

    task automatic test_full_buffer();
        int k;
        int lvl;
        k = 0;
        preload(14'h0204, 16'h5A5A);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            disp_req = 1'b1; disp_addr = 14'(c);
            cpu_req = 1'b1; cpu_we = 1'b1;
            cpu_addr = 14'h0200 + 14'(k); cpu_wdata = 16'hA000 + 16'(k);
            #1;
            lvl = (c < 4) ? c : 4;
            checks += 2;
            if (wbuf_level !== 3'(lvl)) begin errors++; $display("FAIL full_level c=%0d got %0d exp %0d", c, wbuf_level, lvl); end
            if (cpu_ready !== (c < 4)) begin errors++; $display("FAIL full_ready c=%0d got %b exp %b", c, cpu_ready, (c < 4)); end
            if (cpu_ready) k++;
        end
        checks++;
        if (k != 4) begin errors++; $display("FAIL full_accepted got %0d exp 4", k); end
        @(negedge clk);
        disp_req = 1'b0; cpu_req = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            checks += 3;
            if (mem_we !== 1'b1) begin errors++; $display("FAIL drain_we j=%0d got %b exp 1", j, mem_we); end
            if (mem_addr !== 14'h0200 + 14'(j)) begin errors++; $display("FAIL drain_addr j=%0d got %h exp %h", j, mem_addr, 14'h0200 + 14'(j)); end
            if (mem_wdata !== 16'hA000 + 16'(j)) begin errors++; $display("FAIL drain_data j=%0d got %h exp %h", j, mem_wdata, 16'hA000 + 16'(j)); end
            @(negedge clk);
        end
        #1;
        checks += 3;
        if (wbuf_level !== 3'd0) begin errors++; $display("FAIL drain_level got %0d exp 0", wbuf_level); end
        if (mem_we !== 1'b0)     begin errors++; $display("FAIL drain_done_we got %b exp 0", mem_we); end
        if (ram[14'h0204] !== 16'h5A5A) begin errors++; $display("FAIL full_dropped got %h exp 5a5a", ram[14'h0204]); end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (ram[14'h0200 + 14'(j)] !== 16'hA000 + 16'(j)) begin
                errors++; $display("FAIL drain_ram j=%0d got %h exp %h", j, ram[14'h0200 + 14'(j)], 16'hA000 + 16'(j));
            end
        end
    endtask

    task automatic test_raw_order();
        @(negedge clk);
        disp_req = 1'b1; disp_addr = 14'h0;
        for (int v = 1; v <= 4; v++) begin
            cpu_req = 1'b1; cpu_we = (v < 4); cpu_addr = 14'h1FFF; cpu_wdata = 16'(v);
            #1;
            checks++;
            if (cpu_ready !== 1'b1) begin errors++; $display("FAIL raw_ready v=%0d got %b exp 1", v, cpu_ready); end
            @(negedge clk);
        end
        cpu_req = 1'b0; disp_req = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            #1;
            checks += 4;
            if (wbuf_level !== 3'(4 - j)) begin errors++; $display("FAIL raw_level j=%0d got %0d exp %0d", j, wbuf_level, 4 - j); end
            if (mem_we !== 1'b1)       begin errors++; $display("FAIL raw_we j=%0d got %b exp 1", j, mem_we); end
            if (mem_wdata !== 16'(j))  begin errors++; $display("FAIL raw_wdata j=%0d got %h exp %h", j, mem_wdata, 16'(j)); end
            if (cpu_rvalid !== 1'b0)   begin errors++; $display("FAIL raw_early j=%0d got %b exp 0", j, cpu_rvalid); end
            @(negedge clk);
        end
        #1;
        checks += 3;
        if (wbuf_level !== 3'd0)   begin errors++; $display("FAIL raw_rd_level got %0d exp 0", wbuf_level); end
        if (mem_we !== 1'b0)       begin errors++; $display("FAIL raw_rd_we got %b exp 0", mem_we); end
        if (mem_addr !== 14'h1FFF) begin errors++; $display("FAIL raw_rd_addr got %h exp 1fff", mem_addr); end
        @(negedge clk);
        #1;
        checks += 2;
        if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL raw_rvalid got %b exp 1", cpu_rvalid); end
        if (cpu_rdata !== 16'd3) begin errors++; $display("FAIL raw_rdata got %h exp 0003", cpu_rdata); end
    endtask

    task automatic test_random();
        logic [15:0] model [0:15];
        logic [15:0] rexp [$];
        logic [15:0] dexp;
        logic [15:0] e;
        logic        dpend;
        logic        acc;
        int          ops;
        int          tail;
        int          cyc;
        for (int i = 0; i < 16; i++) model[i] = 16'h1000 + 16'(i * 7);
        ops = 0; tail = 0; cyc = 0; dpend = 1'b0; acc = 1'b0; dexp = '0;
        cpu_req = 1'b0;
        while ((ops < 2000 || tail < 30) && cyc < 30000) begin
            @(negedge clk);
            checks++;
            if (disp_valid !== dpend) begin errors++; $display("FAIL rnd_disp_lat cyc=%0d got %b exp %b", cyc, disp_valid, dpend); end
            if (dpend) begin
                checks++;
                if (disp_data !== dexp) begin errors++; $display("FAIL rnd_disp_data cyc=%0d got %h exp %h", cyc, disp_data, dexp); end
            end
            if (cpu_rvalid === 1'b1) begin
                checks++;
                if (rexp.size() == 0) begin
                    errors++; $display("FAIL rnd_spurious_rvalid cyc=%0d got 1 exp 0", cyc);
                end else begin
                    e = rexp.pop_front();
                    if (cpu_rdata !== e) begin errors++; $display("FAIL rnd_rdata cyc=%0d got %h exp %h", cyc, cpu_rdata, e); end
                end
            end
            if (acc) cpu_req = 1'b0;
            if (ops < 2000) begin
                dpend     = (cyc % 16 == 0);
                disp_addr = 14'($urandom_range(15, 0));
                if (!cpu_req && $urandom_range(1, 0) == 1) begin
                    cpu_req   = 1'b1;
                    cpu_we    = 1'($urandom_range(1, 0));
                    cpu_addr  = 14'($urandom_range(15, 0));
                    cpu_wdata = 16'($urandom);
                end
            end else begin
                dpend   = 1'b0;
                cpu_req = 1'b0;
                tail++;
            end
            disp_req = dpend;
            if (dpend) dexp = ram[disp_addr];
            #1;
            acc = cpu_req & cpu_ready;
            if (acc) begin
                if (cpu_we) model[cpu_addr[3:0]] = cpu_wdata;
                else        rexp.push_back(model[cpu_addr[3:0]]);
                ops++;
            end
            cyc++;
        end
        checks += 2;
        if (cyc >= 30000) begin errors++; $display("FAIL rnd_timeout got %0d ops exp 2000", ops); end
        if (rexp.size() != 0) begin errors++; $display("FAIL rnd_lost_reads got %0d exp 0", rexp.size()); end
    endtask

    task automatic test_reset_mid();
        int we_cnt;
        int rv_cnt;
        for (int j = 0; j < 3; j++) preload(14'h0300 + 14'(j), 16'hDEAD);
        @(negedge clk);
        disp_req = 1'b1; disp_addr = 14'h0;
        for (int j = 0; j < 4; j++) begin
            cpu_req = 1'b1; cpu_we = (j < 3);
            cpu_addr = 14'h0300 + 14'(j); cpu_wdata = 16'h7700 + 16'(j);
            @(negedge clk);
        end
        cpu_req = 1'b0;
        #1;
        checks += 3;
        if (wbuf_level !== 3'd3) begin errors++; $display("FAIL mid_level got %0d exp 3", wbuf_level); end
        if (cpu_ready !== 1'b0)  begin errors++; $display("FAIL mid_ready got %b exp 0", cpu_ready); end
        if (disp_valid !== 1'b1) begin errors++; $display("FAIL mid_disp got %b exp 1", disp_valid); end
        @(negedge clk);
        reset = 1'b1; disp_req = 1'b0;
        #1;
        checks += 7;
        if (disp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_disp got %b exp 0", disp_valid); end
        if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_rvalid got %b exp 0", cpu_rvalid); end
        if (cpu_rdata !== 16'h0) begin errors++; $display("FAIL mid_rst_rdata got %h exp 0", cpu_rdata); end
        if (wbuf_level !== 3'd0) begin errors++; $display("FAIL mid_rst_level got %0d exp 0", wbuf_level); end
        if (mem_we !== 1'b0)     begin errors++; $display("FAIL mid_rst_we got %b exp 0", mem_we); end
        if (mem_addr !== 14'h0)  begin errors++; $display("FAIL mid_rst_addr got %h exp 0", mem_addr); end
        if (mem_wdata !== 16'h0) begin errors++; $display("FAIL mid_rst_wdata got %h exp 0", mem_wdata); end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        we_cnt = 0; rv_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (mem_we === 1'b1)     we_cnt++;
            if (cpu_rvalid === 1'b1) rv_cnt++;
            @(negedge clk);
        end
        checks += 2;
        if (we_cnt != 0) begin errors++; $display("FAIL mid_post_writes got %0d exp 0", we_cnt); end
        if (rv_cnt != 0) begin errors++; $display("FAIL mid_post_rvalid got %0d exp 0", rv_cnt); end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (ram[14'h0300 + 14'(j)] !== 16'hDEAD) begin
                errors++; $display("FAIL mid_ram j=%0d got %h exp dead", j, ram[14'h0300 + 14'(j)]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        disp_req = 1'b0; disp_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        test_reset();
        test_write_read();
        test_display();
        test_full_buffer();
        test_raw_order();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
